// File: rtl/fetch_buffer_if.sv
// Fetch-stage bus: PC handshake, imem read port and decode-side FIFO head.
// master = environment (PC/imem/decode), slave = fetch_buffer.
`timescale 1ns/1ps
interface fetch_buffer_if #(
  parameter int WORD_W    = 32,
  parameter int BUF_DEPTH = 2
);
  logic [WORD_W-1:0]              pc_addr;
  logic                           pc_wait;
  logic                           flush;
  logic                           halt;
  logic                           imemREN;
  logic [WORD_W-1:0]              imemaddr;
  logic                           ihit;
  logic [WORD_W-1:0]              imemload;
  logic [WORD_W-1:0]              instr;
  logic [WORD_W-1:0]              instr_pc;
  logic                           instr_valid;
  logic                           instr_ready;
  logic [$clog2(BUF_DEPTH+1)-1:0] count;

  modport master (
    output pc_addr, flush, halt, ihit, imemload, instr_ready,
    input  pc_wait, imemREN, imemaddr, instr, instr_pc, instr_valid, count
  );

  modport slave (
    input  pc_addr, flush, halt, ihit, imemload, instr_ready,
    output pc_wait, imemREN, imemaddr, instr, instr_pc, instr_valid, count
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction-fetch buffer: issues imem reads at the PC address, stores
// returned {pc, word} pairs in a small FIFO and presents the head to decode.
// Optional feature macro FETCH_BYPASS_EN: when the FIFO is empty an accepted
// word is forwarded to decode in the same cycle.
`timescale 1ns/1ps
module fetch_buffer #(
  parameter int BUF_DEPTH = 2,
  parameter int WORD_W    = 32
) (
  input logic          CLK,
  input logic          RST,
  fetch_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic {FETCH, HALTED} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WORD_W-1:0]  data_q [BUF_DEPTH];
  logic [WORD_W-1:0]  pc_q   [BUF_DEPTH];

  logic full, empty, imem_ren, accept, byp_vld, byp_take, push, pop;

  assign full  = (count_q == CNT_W'(BUF_DEPTH));
  assign empty = (count_q == '0);

  // Read enable is blocked in reset, when halted, when full, and on
  // flush/halt cycles so neither a redirect nor a halt can admit a word.
  assign imem_ren = ~RST & (state_q == FETCH) & ~full & ~bus.flush & ~bus.halt;
  assign accept   = imem_ren & bus.ihit;

`ifdef FETCH_BYPASS_EN
  // accept already excludes flush, so flush suppresses the bypass too.
  assign byp_vld = empty & accept;
`else
  assign byp_vld = 1'b0;
`endif
  assign byp_take = byp_vld & bus.instr_ready;

  // A bypassed-and-consumed word never enters the FIFO.
  assign push = accept & ~byp_take;
  // A pop in a flush cycle is void; empty FIFO ignores instr_ready.
  assign pop  = ~empty & bus.instr_ready & ~bus.flush;

  assign bus.imemREN  = imem_ren;
  assign bus.imemaddr = bus.pc_addr;
  assign bus.count    = count_q;

  // PC hold: held in reset/halt, released on flush so the PC takes its
  // redirect target, otherwise advances only on an accepted fetch.
  always_comb begin
    bus.pc_wait = 1'b1;
    if (RST || state_q == HALTED) begin
      bus.pc_wait = 1'b1;
    end else if (bus.flush) begin
      bus.pc_wait = 1'b0;
    end else begin
      bus.pc_wait = ~accept | bus.halt;
    end
  end

  // Head presentation: FIFO head when occupied, zeros when empty.
  always_comb begin
    bus.instr       = '0;
    bus.instr_pc    = '0;
    bus.instr_valid = 1'b0;
    if (!empty) begin
      bus.instr       = data_q[rd_ptr_q];
      bus.instr_pc    = pc_q[rd_ptr_q];
      bus.instr_valid = 1'b1;
    end
`ifdef FETCH_BYPASS_EN
    else if (byp_vld) begin
      bus.instr       = bus.imemload;
      bus.instr_pc    = bus.pc_addr;
      bus.instr_valid = 1'b1;
    end
`endif
  end

  // Next-state: halt latch, flush clear, pointer/occupancy bookkeeping.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (state_q == FETCH && bus.halt) begin
      state_d = HALTED;
    end
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Control state with asynchronous reset: drops all entries at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= FETCH;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: written on push only; validity is tracked by count.
  always_ff @(posedge CLK) begin
    if (push) begin
      data_q[wr_ptr_q] <= bus.imemload;
      pc_q[wr_ptr_q]   <= bus.pc_addr;
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: a queue of expected {pc, word} entries
// is the reference FIFO; a negedge monitor compares the decode-side head.
`timescale 1ns/1ps
module tb_fetch_buffer;
  localparam int DEPTH = 2;
  localparam int W     = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  fetch_buffer_if #(.WORD_W(W), .BUF_DEPTH(DEPTH)) bus();

  fetch_buffer #(.BUF_DEPTH(DEPTH), .WORD_W(W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  logic [63:0] sb[$];
  bit          halted_m = 1'b0;
  bit          mon_en   = 1'b0;
  bit          byp_on   = 1'b0;
  logic [63:0] byp_ent  = '0;
  int          total    = 0;
  int          bad      = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // One bus cycle: drive, predict control outputs from occupancy, update model at the edge.
  task automatic drive(input logic [31:0] pc, input bit ih, input logic [31:0] wd,
                       input bit rdy, input bit fl, input bit hl);
    bit full, ren, acc, pcw, byp;
    bus.pc_addr     = pc;
    bus.ihit        = ih;
    bus.imemload    = wd;
    bus.instr_ready = rdy;
    bus.flush       = fl;
    bus.halt        = hl;
    full = (sb.size() == DEPTH);
    ren  = !halted_m && !full && !fl && !hl;
    acc  = ren && ih;
    pcw  = halted_m ? 1'b1 : (fl ? 1'b0 : (!acc || hl));
`ifdef FETCH_BYPASS_EN
    byp = acc && (sb.size() == 0);
`else
    byp = 1'b0;
`endif
    byp_on  = byp;
    byp_ent = {pc, wd};
    #1;
    chk("imemREN", 64'(bus.imemREN), 64'(ren));
    chk("pc_wait", 64'(bus.pc_wait), 64'(pcw));
    chk("imemaddr", 64'(bus.imemaddr), 64'(pc));
    @(posedge CLK);
    if (fl) sb.delete();
    else if (acc && !(byp && rdy)) sb.push_back({pc, wd});
    if (hl) halted_m = 1'b1;
    byp_on = 1'b0;
    #1;
  endtask

  // Monitor: head/occupancy check mid-cycle; pops the scoreboard on handshake.
  always @(negedge CLK) begin
    if (mon_en && !RST) begin
      chk("instr_valid", 64'(bus.instr_valid), 64'((sb.size() > 0) || byp_on));
      chk("count", 64'(bus.count), 64'(sb.size()));
      if (sb.size() > 0) begin
        chk("instr", 64'(bus.instr), 64'(sb[0][31:0]));
        chk("instr_pc", 64'(bus.instr_pc), 64'(sb[0][63:32]));
        if (bus.instr_ready && !bus.flush) void'(sb.pop_front());
      end else if (byp_on) begin
        chk("byp_instr", 64'(bus.instr), 64'(byp_ent[31:0]));
        chk("byp_instr_pc", 64'(bus.instr_pc), 64'(byp_ent[63:32]));
      end else begin
        chk("empty_instr", 64'(bus.instr), 64'd0);
        chk("empty_instr_pc", 64'(bus.instr_pc), 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.pc_addr = '0; bus.ihit = 1'b0; bus.imemload = '0;
    bus.instr_ready = 1'b0; bus.flush = 1'b0; bus.halt = 1'b0;
    #2;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst_instr", 64'(bus.instr), 64'd0);
    chk("rst_instr_pc", 64'(bus.instr_pc), 64'd0);
    chk("rst_imemREN", 64'(bus.imemREN), 64'd0);
    chk("rst_pc_wait", 64'(bus.pc_wait), 64'd1);
    @(posedge CLK); #1;
    RST = 1'b0;
    mon_en = 1'b1;

    // Single fetch with ready decode, then one idle cycle to observe it.
    drive(32'h0, 1, 32'h2008000A, 1, 0, 0);
    drive(32'h4, 0, 32'h0, 1, 0, 0);

    // Fill to full with decode stalled, then drain with refill.
    for (int i = 0; i < 3; i++) drive(32'h8 + 4*i, 1, 32'h1000 + i, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(32'h20 + 4*i, 1, 32'h2000 + i, 1, 0, 0);

    // Asynchronous reset mid-stream with a full FIFO.
    for (int i = 0; i < 3; i++) drive(32'h40 + 4*i, 1, 32'h3000 + i, 0, 0, 0);
    mon_en = 1'b0;
    bus.ihit = 1'b0;
    RST = 1'b1;
    #1;
    chk("midrst_valid", 64'(bus.instr_valid), 64'd0);
    chk("midrst_count", 64'(bus.count), 64'd0);
    chk("midrst_pc_wait", 64'(bus.pc_wait), 64'd1);
    chk("midrst_imemREN", 64'(bus.imemREN), 64'd0);
    sb.delete();
    halted_m = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    mon_en = 1'b1;
    drive(32'h80, 0, 32'h0, 0, 0, 0);

    // Flush with full FIFO, same-cycle ihit and ready.
    for (int i = 0; i < 2; i++) drive(32'h90 + 4*i, 1, 32'h4000 + i, 0, 0, 0);
    drive(32'h98, 1, 32'h4444, 1, 1, 0);
    drive(32'h200, 0, 32'h0, 0, 0, 0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      drive($urandom & 32'hFFFF_FFFC, ($urandom_range(0, 3) != 0),
            $urandom, ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0), 0);
    end

    // Halt with one entry buffered and a same-cycle ihit.
    drive(32'h300, 0, 32'h0, 0, 1, 0);
    drive(32'h304, 1, 32'hAC220004, 0, 0, 0);
    drive(32'h308, 1, 32'h5555, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(32'h30C + 4*i, 1, 32'h6000 + i, 1, 0, 0);
    drive(32'h400, 1, 32'h7777, 0, 1, 0);
    drive(32'h404, 1, 32'h8888, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
